// File: rtl/util_dac_diff_encoder_if.sv
// rtl/util_dac_diff_encoder_if.sv - symbol input and DAC word output bundle for util_dac_diff_encoder
interface util_dac_diff_encoder_if #(
  parameter int DATA_WIDTH = 128
);
  logic [1:0]            s_diff;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_enable;
  logic                  rd_dunf;
  logic                  busy;

  modport slave (
    input  s_diff, s_valid, rd_enable,
    output s_ready, rd_data, rd_valid, rd_dunf, busy
  );

  modport master (
    output s_diff, s_valid, rd_enable,
    input  s_ready, rd_data, rd_valid, rd_dunf, busy
  );
endinterface

// File: rtl/util_dac_diff_encoder.sv
// rtl/util_dac_diff_encoder.sv - 1553 differential symbol to DAC word encoder feeding util_dac_switch
module util_dac_diff_encoder #(
  parameter int                      BYTE_WIDTH       = 16,
  parameter int                      SAMPLE_WIDTH     = 16,
  parameter int                      WORDS_PER_SYMBOL = 4,
  parameter logic [SAMPLE_WIDTH-1:0] AMPLITUDE        = 16'h3FFF
) (
  input logic                    clk,
  input logic                    rst,
  util_dac_diff_encoder_if.slave bus
);
  localparam int DATA_W = BYTE_WIDTH * 8;
  localparam int LANES  = DATA_W / SAMPLE_WIDTH;
  localparam int CNT_W  = (WORDS_PER_SYMBOL > 1) ? $clog2(WORDS_PER_SYMBOL) : 1;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(WORDS_PER_SYMBOL - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic [SAMPLE_WIDTH-1:0] AMP_NEG  = ~AMPLITUDE + SAMPLE_WIDTH'(1);

  // ST_HOLD: holding register occupied; ST_FULL: holding register and skid buffer occupied
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        skid_sym_q, skid_sym_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dunf_q, dunf_d;

  logic hold_full;
  logic skid_full;
  logic accept;
  logic consume;
  logic last_word;

  function automatic logic [DATA_W-1:0] map_word(input logic [1:0] sym);
    logic [SAMPLE_WIDTH-1:0] sample;
    case (sym)
      2'b10:   sample = AMPLITUDE;
      2'b01:   sample = AMP_NEG;
      default: sample = '0;
    endcase
    return {LANES{sample}};
  endfunction

  assign hold_full = (state_q != ST_EMPTY);
  assign skid_full = (state_q == ST_FULL);
  assign accept    = bus.s_valid & bus.s_ready;
  assign consume   = bus.rd_enable & hold_full;
  assign last_word = consume & (cnt_q == CNT_LAST);

  assign bus.s_ready  = ~skid_full & ~rst;
  assign bus.rd_valid = hold_full;
  assign bus.rd_data  = data_q;
  assign bus.rd_dunf  = dunf_q;
  assign bus.busy     = hold_full | skid_full;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    skid_sym_d = skid_sym_q;
    data_d     = data_q;
    dunf_d     = bus.rd_enable & ~hold_full;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          data_d  = map_word(bus.s_diff);
        end
      end
      ST_HOLD: begin
        if (last_word) begin
          cnt_d = '0;
          // Final word and a new symbol on the same edge: load directly, no bubble
          if (accept) begin
            data_d = map_word(bus.s_diff);
          end else begin
            state_d = ST_EMPTY;
            data_d  = '0;
          end
        end else begin
          if (consume) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (accept) begin
            skid_sym_d = bus.s_diff;
            state_d    = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (last_word) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          data_d  = map_word(skid_sym_q);
        end else if (consume) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        cnt_d   = '0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      cnt_q      <= '0;
      skid_sym_q <= 2'b00;
      data_q     <= '0;
      dunf_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      skid_sym_q <= skid_sym_d;
      data_q     <= data_d;
      dunf_q     <= dunf_d;
    end
  end
endmodule

// File: tb/tb_util_dac_diff_encoder.sv
// tb/tb_util_dac_diff_encoder.sv - self-checking bench for util_dac_diff_encoder
module tb_util_dac_diff_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [127:0] q  [$];
  logic [63:0]  q2 [$];

  util_dac_diff_encoder_if #(.DATA_WIDTH(128)) bus ();
  util_dac_diff_encoder_if #(.DATA_WIDTH(64))  bus2 ();

  util_dac_diff_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  util_dac_diff_encoder #(
    .BYTE_WIDTH       (8),
    .SAMPLE_WIDTH     (32),
    .WORDS_PER_SYMBOL (1),
    .AMPLITUDE        (32'h0000_3FFF)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] map16(input logic [1:0] sym);
    if (sym == 2'b10) return 16'h3FFF;
    if (sym == 2'b01) return 16'hC001;
    return 16'h0000;
  endfunction

  function automatic logic [31:0] map32(input logic [1:0] sym);
    if (sym == 2'b10) return 32'h0000_3FFF;
    if (sym == 2'b01) return 32'hFFFF_C001;
    return 32'h0000_0000;
  endfunction

  // Drives one cycle of stimulus and records the expected words of an accepted symbol
  task automatic step(input logic sv, input logic [1:0] sd, input logic re,
                      output logic acc, output logic con);
    @(negedge clk);
    bus.s_valid   = sv;
    bus.s_diff    = sd;
    bus.rd_enable = re;
    #1;
    acc = sv & bus.s_ready;
    con = re & bus.rd_valid;
    if (acc) for (int i = 0; i < 4; i++) q.push_back({8{map16(sd)}});
  endtask

  task automatic step2(input logic sv, input logic [1:0] sd, input logic re,
                       output logic acc, output logic con);
    @(negedge clk);
    bus2.s_valid   = sv;
    bus2.s_diff    = sd;
    bus2.rd_enable = re;
    #1;
    acc = sv & bus2.s_ready;
    con = re & bus2.rd_valid;
    if (acc) q2.push_back({2{map32(sd)}});
  endtask

  task automatic test_reset();
    logic acc, con;
    logic [127:0] exp;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.rd_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.rd_dunf !== 1'b0) begin errors++; $display("FAIL reset_dunf: got %b expected 0", bus.rd_dunf); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.s_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", bus.s_ready); end

    step(1'b1, 2'b10, 1'b0, acc, con);
    step(1'b0, 2'b00, 1'b1, acc, con);
    checks++; if (con !== 1'b1) begin errors++; $display("FAIL mid_consume: got %b expected 1", con); end
    if (con && q.size() > 0) begin
      exp = q.pop_front();
      checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL mid_word: got %h expected %h", bus.rd_data, exp); end
    end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL async_data: got %h expected 0", bus.rd_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b expected 0", bus.s_ready); end
    @(posedge clk); #1;
    checks++; if (bus.rd_dunf !== 1'b0) begin errors++; $display("FAIL reset_no_dunf: got %b expected 0", bus.rd_dunf); end
    @(negedge clk);
    bus.rd_enable = 1'b0;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_single();
    logic acc, con, prev;
    logic [127:0] exp;
    int words = 0;
    step(1'b0, 2'b00, 1'b0, acc, con);
    prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(i == 0, 2'b10, 1'b1, acc, con);
      checks++; if (bus.rd_dunf !== prev) begin errors++; $display("FAIL single_dunf[%0d]: got %b expected %b", i, bus.rd_dunf, prev); end
      prev = ~bus.rd_valid;
      if (con) begin
        words++;
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL single_word[%0d]: got %h expected %h", i, bus.rd_data, exp); end
        checks++; if (bus.rd_data !== {8{16'h3FFF}}) begin errors++; $display("FAIL single_lanes[%0d]: got %h expected all 3fff", i, bus.rd_data); end
      end else begin
        checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL single_idle_data[%0d]: got %h expected 0", i, bus.rd_data); end
      end
    end
    checks++; if (words !== 4) begin errors++; $display("FAIL single_count: got %0d expected 4", words); end
    step(1'b0, 2'b00, 1'b0, acc, con);
  endtask

  task automatic test_back_to_back();
    logic acc, con, seen;
    logic [1:0] syms [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
    logic [127:0] exp;
    int idx = 0, words = 0, bubbles = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 40 && words < 16; cyc++) begin
      step(idx < 4, (idx < 4) ? syms[idx] : 2'b00, 1'b1, acc, con);
      if (acc) idx++;
      if (seen && !bus.rd_valid) bubbles++;
      if (bus.rd_valid) seen = 1'b1;
      if (con) begin
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL b2b_word[%0d]: got %h expected %h", words, bus.rd_data, exp); end
        words++;
      end
    end
    checks++; if (words !== 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", words); end
    checks++; if (bubbles !== 0) begin errors++; $display("FAIL b2b_bubbles: got %0d expected 0", bubbles); end
    step(1'b0, 2'b00, 1'b0, acc, con);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b expected 0", bus.rd_valid); end
  endtask

  task automatic test_backpressure();
    logic acc, con;
    logic [1:0] sd;
    logic [127:0] exp;
    int n_acc = 0, words = 0;
    sd = 2'($urandom_range(1, 2));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, sd, 1'b0, acc, con);
      if (acc) begin
        n_acc++;
        sd = 2'($urandom);
      end
    end
    checks++; if (n_acc !== 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", n_acc); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", bus.s_ready); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b expected 1", bus.busy); end
    exp = (q.size() > 0) ? q[0] : 'x;
    checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL bp_hold: got %h expected %h", bus.rd_data, exp); end
    for (int cyc = 0; cyc < 40 && q.size() > 0; cyc++) begin
      step(1'b0, 2'b00, 1'b1, acc, con);
      if (con) begin
        exp = q.pop_front();
        checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", words, bus.rd_data, exp); end
        words++;
      end
    end
    checks++; if (words !== 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", words); end
    step(1'b0, 2'b00, 1'b0, acc, con);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", bus.busy); end
  endtask

  task automatic test_underflow();
    logic acc, con, prev, re;
    int highs = 0;
    step(1'b0, 2'b00, 1'b0, acc, con);
    prev = 1'b0;
    for (int i = 0; i < 7; i++) begin
      re = (i < 5);
      step(1'b0, 2'b00, re, acc, con);
      checks++; if (bus.rd_dunf !== prev) begin errors++; $display("FAIL unf_dunf[%0d]: got %b expected %b", i, bus.rd_dunf, prev); end
      checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL unf_data[%0d]: got %h expected 0", i, bus.rd_data); end
      if (bus.rd_dunf === 1'b1) highs++;
      prev = re & ~bus.rd_valid;
    end
    checks++; if (highs !== 5) begin errors++; $display("FAIL unf_count: got %0d expected 5", highs); end
    step(1'b0, 2'b00, 1'b0, acc, con);
  endtask

  task automatic test_corner();
    logic acc, con;
    logic [63:0] exp;
    int n_acc = 0, words = 0;
    for (int i = 0; i < 300; i++) begin
      step2(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom_range(0, 1)), acc, con);
      if (acc) n_acc++;
      if (con) begin
        exp = (q2.size() > 0) ? q2.pop_front() : 'x;
        checks++; if (bus2.rd_data !== exp) begin errors++; $display("FAIL corner_word[%0d]: got %h expected %h", words, bus2.rd_data, exp); end
        words++;
      end
    end
    for (int cyc = 0; cyc < 20 && q2.size() > 0; cyc++) begin
      step2(1'b0, 2'b00, 1'b1, acc, con);
      if (con) begin
        exp = q2.pop_front();
        checks++; if (bus2.rd_data !== exp) begin errors++; $display("FAIL corner_drain[%0d]: got %h expected %h", words, bus2.rd_data, exp); end
        words++;
      end
    end
    checks++; if (words !== n_acc) begin errors++; $display("FAIL corner_count: got %0d expected %0d", words, n_acc); end
    checks++; if (q2.size() !== 0) begin errors++; $display("FAIL corner_left: got %0d expected 0", q2.size()); end
    step2(1'b0, 2'b00, 1'b0, acc, con);
    checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL corner_busy: got %b expected 0", bus2.busy); end
  endtask

  initial begin
    bus.s_valid    = 1'b0;
    bus.s_diff     = 2'b00;
    bus.rd_enable  = 1'b0;
    bus2.s_valid   = 1'b0;
    bus2.s_diff    = 2'b00;
    bus2.rd_enable = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_underflow();
    test_corner();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/util_dac_diff_encoder.md
Name: util_dac_diff_encoder

Overview:
Upstream feeder for util_dac_switch. It converts a stream of 1553 differential bit-pairs into DAC sample words on the switch's rd_data/rd_valid/rd_enable input. Each accepted symbol is held for a fixed number of DAC words and mapped to a signed amplitude. Every sample lane in the output word carries that amplitude.

Parameters:
BYTE_WIDTH, 16, output word width in bytes; rd_data is BYTE_WIDTH*8 bits.
SAMPLE_WIDTH, 16, bits per DAC sample lane; must divide BYTE_WIDTH*8, giving LANES = BYTE_WIDTH*8/SAMPLE_WIDTH.
WORDS_PER_SYMBOL, 4, DAC words emitted per input symbol; must be at least 1.
AMPLITUDE, 16'h3FFF, positive drive level in two's complement, SAMPLE_WIDTH bits.

Ports:
clk  in  1  single block clock.
rst  in  1  asynchronous, active-high reset.
s_diff  in  2  symbol {pos,neg}: 2'b10 = +AMPLITUDE, 2'b01 = -AMPLITUDE, 2'b00 or 2'b11 = 0 (idle).
s_valid  in  1  s_diff is valid.
s_ready  out  1  block accepts s_diff this cycle.
rd_data  out  BYTE_WIDTH*8  LANES copies of the current sample; lane 0 is in the LSBs.
rd_valid  out  1  rd_data holds an encoded symbol word.
rd_enable  in  1  consumer takes a word this cycle.
rd_dunf  out  1  one-cycle pulse when rd_enable is high and no word is available.
busy  out  1  holding register or skid buffer is occupied.

Behaviour:
- Reset (asynchronous assert, synchronous release): rd_data=0, rd_valid=0, s_ready=0 while rst is high, rd_dunf=0, busy=0, counter=0, skid buffer empty.
- Input handshake: a symbol transfers when s_valid & s_ready are both high. The block has a one-entry skid buffer. s_ready = ~skid_full & ~rst.
- Storage:
  - Holding register: current symbol plus word counter cnt, 0..WORDS_PER_SYMBOL-1.
  - Skid buffer: next symbol.
- Output word: rd_valid=1 whenever the holding register is full. rd_data is registered: it changes only on the clock edge where the holding register loads.
- Consume: on rd_enable & rd_valid, cnt increments.
  - When cnt = WORDS_PER_SYMBOL-1 and a word is consumed, the holding register reloads from the skid buffer if it is full, otherwise directly from an accepted input. cnt returns to 0. If neither source is available, the holding register empties and rd_valid=0 on the next cycle.
- Load latency: with the holding register empty, a symbol accepted at edge N gives rd_valid=1 with the mapped data after edge N. Input is never routed combinationally to the output.
- Simultaneous accept and final consume: the accepted symbol goes straight into the holding register when the skid buffer is empty. Throughput is 1 symbol per WORDS_PER_SYMBOL words with no bubbles.
- Skid buffer: fills when a symbol is accepted and the holding register is full and not finishing this cycle. While the skid buffer is full, s_ready=0.
- Underflow: rd_dunf is registered, =1 for one cycle after any edge where rd_enable=1 and rd_valid=0. It stays high for consecutive underflow cycles. rd_data is driven to 0 while rd_valid=0.
- rd_enable held low: the output word, cnt and the skid buffer hold. There is no data loss.
- Sign mapping: -AMPLITUDE is the two's complement negate, truncated to SAMPLE_WIDTH.
- WORDS_PER_SYMBOL=1: every consume reloads the holding register; the counter logic degenerates cleanly.
- Reset mid-symbol: the pending symbols are discarded, the output drops to the reset values immediately, and no rd_dunf is pulsed.
- busy = holding register full | skid buffer full.

Test Plan:
- Reset (asynchronous): assert rst mid-symbol without a clock edge. rd_valid, rd_data and busy go to 0 immediately. After release, s_ready=1 on the first edge.
- Single symbol: default parameters, send 2'b10 with rd_enable=1. Four words appear, each with all 8 lanes = 16'h3FFF. Then rd_valid=0, and rd_dunf=1 on the next edge.
- Back-to-back: stream 10,01,00,11 continuously with rd_enable=1. Output is 4x16'h3FFF, 4x16'hC001, then 8x16'h0000 with rd_valid continuously high and no bubbles.
- Backpressure: rd_enable=0 for 20 cycles while s_valid=1. After 2 symbols are accepted, s_ready=0. On resuming rd_enable, every word is emitted in order with none lost.
- Underflow: rd_enable=1 with s_valid=0 for 5 cycles. rd_dunf is high for 5 cycles and rd_data=0.
- Parameter corner: WORDS_PER_SYMBOL=1, SAMPLE_WIDTH=32, BYTE_WIDTH=8. Random symbols with random rd_enable produce one word per symbol, with 2 lanes equal to the sign-extended mapping, checked against a scoreboard.
